// File: rtl/axi_burst_write_engine_pkg.sv
// rtl/axi_burst_write_engine_pkg.sv - shared constants, FSM encoding and helpers
// Purpose: AXI encodings, burst-engine state type and clogb2 used by the engine and its FIFO.
package axi_burst_write_engine_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ceiling log2; clogb2(16) = 4, clogb2(4) = 2.
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_burst_write_engine_beat_fifo.sv
// rtl/axi_burst_write_engine_beat_fifo.sv - synchronous beat FIFO for the burst write engine
// Purpose: buffers incoming data beats until the W channel accepts them.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push     write i_data (ignored when full)
//   i_data     beat payload
//   i_pop      drop the head entry (ignored when empty)
//   o_data     head entry, read straight from the storage registers
//   o_full     DEPTH entries held
//   o_empty    no entries held
//   o_count    number of entries held, 0..DEPTH
module axi_burst_write_engine_beat_fifo
  import axi_burst_write_engine_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [clogb2(DEPTH):0]    o_count
);

  localparam int PW   = clogb2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNTW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/axi_burst_write_engine.sv
// rtl/axi_burst_write_engine.sv - single AXI4 INCR write burst per trigger
// Purpose: on a rising edge of init_axi_txn, writes one C_M_AXI_BURST_LEN-beat burst to
//   base_addr+bias_addr using beats streamed in on data_en/data, then pulses
//   init_axi_txn_done once the B response has been taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (aborts any burst)
//   init_axi_txn             trigger level; its rising edge starts a burst from IDLE
//   base_addr, bias_addr     burst address components, summed modulo 2^ADDR_WIDTH
//   data_en, data            beat stream from the scheduler
//   init_axi_txn_done        one-cycle completion pulse
//   txn_error, overflow      sticky status, cleared by the next accepted trigger
//   busy                     engine not idle
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4 write-channel master signals
module axi_burst_write_engine
  import axi_burst_write_engine_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init_axi_txn,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [ADDR_WIDTH-1:0]             bias_addr,
  input  logic                              data_en,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     data,
  output logic                              init_axi_txn_done,
  output logic                              txn_error,
  output logic                              overflow,
  output logic                              busy,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int            CW     = clogb2(C_M_AXI_BURST_LEN) + 1;
  localparam logic [CW-1:0] LEN    = CW'(C_M_AXI_BURST_LEN);
  localparam logic [CW-1:0] LEN_M1 = CW'(C_M_AXI_BURST_LEN - 1);

  state_t                          r_state;
  state_t                          w_state_next;
  logic                            r_init_q;
  logic                            r_awvalid;
  logic                            r_aw_done;
  logic [ADDR_WIDTH-1:0]           r_awaddr;
  logic [CW-1:0]                   r_captured;
  logic [CW-1:0]                   r_sent;
  logic                            r_txn_error;
  logic                            r_overflow;

  logic                            w_trig;
  logic                            w_start;
  logic                            w_aw_hs;
  logic                            w_wvalid;
  logic                            w_wlast;
  logic                            w_w_hs;
  logic                            w_beat_in;
  logic                            w_push;
  logic                            w_drop;
  logic                            w_aw_fin;
  logic                            w_w_fin;
  logic                            w_b_hs;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_fifo_data;
  logic                            w_fifo_full;
  logic                            w_fifo_empty;
  logic [CW-1:0]                   w_fifo_count;
  logic                            w_unused_level;

  assign w_trig    = init_axi_txn & ~r_init_q;
  assign w_start   = (r_state == ST_IDLE) & w_trig;
  assign w_aw_hs   = r_awvalid & m_axi_awready;
  assign w_wvalid  = (r_state == ST_RUN) & ~w_fifo_empty & (r_sent < LEN);
  assign w_wlast   = w_wvalid & (r_sent == LEN_M1);
  assign w_w_hs    = w_wvalid & m_axi_wready;
  // Beats outside RUN are silently ignored; inside RUN anything past the burst is dropped.
  assign w_beat_in = (r_state == ST_RUN) & data_en;
  assign w_push    = w_beat_in & (r_captured < LEN) & ~w_fifo_full;
  assign w_drop    = w_beat_in & ~w_push;
  // Either half may finish first; a same-cycle finish still moves on that cycle.
  assign w_aw_fin  = r_aw_done | w_aw_hs;
  assign w_w_fin   = (r_sent == LEN) | (w_w_hs & w_wlast);
  assign w_b_hs    = (r_state == ST_RESP) & m_axi_bvalid;

  // The FIFO level is only observed for debug; the engine uses full/empty.
  assign w_unused_level = ^w_fifo_count;

  axi_burst_write_engine_beat_fifo #(
    .DEPTH (C_M_AXI_BURST_LEN),
    .WIDTH (C_M_AXI_DATA_WIDTH)
  ) u_beat_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (data),
    .i_pop   (w_w_hs),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_trig) w_state_next = ST_RUN;
      ST_RUN:  if (w_aw_fin && w_w_fin) w_state_next = ST_RESP;
      ST_RESP: if (m_axi_bvalid) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_q    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_awaddr    <= '0;
      r_captured  <= '0;
      r_sent      <= '0;
      r_txn_error <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_init_q <= init_axi_txn;
      if (w_start) begin
        r_awaddr    <= base_addr + bias_addr;
        r_awvalid   <= 1'b1;
        r_aw_done   <= 1'b0;
        r_captured  <= '0;
        r_sent      <= '0;
        r_txn_error <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (w_push) r_captured <= r_captured + CW'(1);
        if (w_w_hs) r_sent     <= r_sent + CW'(1);
        if (w_drop) r_overflow <= 1'b1;
        if (w_b_hs) r_txn_error <= (m_axi_bresp != AXI_RESP_OKAY);
      end
    end
  end

  assign init_axi_txn_done = (r_state == ST_DONE);
  assign txn_error         = r_txn_error;
  assign overflow          = r_overflow;
  assign busy              = (r_state != ST_IDLE);
  assign m_axi_awaddr      = r_awaddr;
  assign m_axi_awlen       = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi_awsize      = 3'(clogb2(C_M_AXI_DATA_WIDTH / 8));
  assign m_axi_awburst     = AXI_BURST_INCR;
  assign m_axi_awvalid     = r_awvalid;
  // Gate the head so wdata reads zero whenever no beat is being offered.
  assign m_axi_wdata       = w_wvalid ? w_fifo_data : '0;
  assign m_axi_wstrb       = '1;
  assign m_axi_wlast       = w_wlast;
  assign m_axi_wvalid      = w_wvalid;
  assign m_axi_bready      = (r_state == ST_RESP);

endmodule

// File: tb/tb_axi_burst_write_engine.sv
// tb/tb_axi_burst_write_engine.sv - directed self-checking bench for axi_burst_write_engine
module tb_axi_burst_write_engine;

  localparam int BL = 16;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_axi_txn = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] bias_addr = '0;
  logic          data_en = 1'b0;
  logic [DW-1:0] data = '0;
  logic          init_axi_txn_done;
  logic          txn_error;
  logic          overflow;
  logic          busy;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b1;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int aw_count, done_count, wlast_count, wlast_idx, wlast_cyc;
  int aw_hs_cyc, resp_cyc, done_cyc, wdone_cnt;
  logic [AW-1:0] aw_addr_seen;
  logic [DW-1:0] w_q[$];
  logic err_at_done;

  logic       aw_delay_en = 1'b0;
  logic       wtoggle = 1'b0;
  logic [1:0] resp_code = 2'b00;

  always #5 clk = ~clk;

  axi_burst_write_engine #(
    .C_M_AXI_BURST_LEN (BL),
    .C_M_AXI_DATA_WIDTH(DW),
    .ADDR_WIDTH        (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .init_axi_txn     (init_axi_txn),
    .base_addr        (base_addr),
    .bias_addr        (bias_addr),
    .data_en          (data_en),
    .data             (data),
    .init_axi_txn_done(init_axi_txn_done),
    .txn_error        (txn_error),
    .overflow         (overflow),
    .busy             (busy),
    .m_axi_awaddr     (m_axi_awaddr),
    .m_axi_awlen      (m_axi_awlen),
    .m_axi_awsize     (m_axi_awsize),
    .m_axi_awburst    (m_axi_awburst),
    .m_axi_awvalid    (m_axi_awvalid),
    .m_axi_awready    (m_axi_awready),
    .m_axi_wdata      (m_axi_wdata),
    .m_axi_wstrb      (m_axi_wstrb),
    .m_axi_wlast      (m_axi_wlast),
    .m_axi_wvalid     (m_axi_wvalid),
    .m_axi_wready     (m_axi_wready),
    .m_axi_bresp      (m_axi_bresp),
    .m_axi_bvalid     (m_axi_bvalid),
    .m_axi_bready     (m_axi_bready)
  );

  // Handshake monitor: inputs settle at posedge+1, so the negedge sees what the next edge takes.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_count++;
        aw_addr_seen = m_axi_awaddr;
        aw_hs_cyc = cyc;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_q.push_back(m_axi_wdata);
        if (m_axi_wlast) begin
          wlast_count++;
          wlast_idx = w_q.size() - 1;
          wlast_cyc = cyc;
        end
      end
      if (m_axi_bready && resp_cyc < 0) resp_cyc = cyc;
      if (init_axi_txn_done) begin
        done_count++;
        done_cyc = cyc;
        err_at_done = txn_error;
      end
    end
  end

  // Slave responder: B answers in the first RESP cycle; AW can be held until W is long done.
  always @(posedge clk) begin
    #1;
    if (w_q.size() >= BL) wdone_cnt++;
    m_axi_awready = !aw_delay_en || (wdone_cnt >= 10);
    m_axi_wready  = wtoggle ? ~m_axi_wready : 1'b1;
    m_axi_bvalid  = m_axi_bready;
    m_axi_bresp   = m_axi_bready ? resp_code : 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    aw_count = 0; done_count = 0; wlast_count = 0; wlast_idx = -1; wlast_cyc = -1;
    aw_hs_cyc = -1; resp_cyc = -1; done_cyc = -1; wdone_cnt = 0;
    aw_addr_seen = '0; err_at_done = 1'b0;
    w_q.delete();
  endtask

  // Returns just after the edge that accepted the trigger.
  task automatic trigger(input logic [AW-1:0] b, input logic [AW-1:0] o);
    base_addr = b;
    bias_addr = o;
    init_axi_txn = 1'b1;
    tick();
    init_axi_txn = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) begin
      data_en = 1'b1;
      data = first + DW'(i);
      tick();
    end
    data_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_count == 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (done_count == 0) begin
      bad++;
      $display("FAIL %s_done_timeout: no done pulse after %0d cycles", name, n);
    end
    tick();
    tick();
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] first);
    int errs;
    errs = 0;
    for (int i = 0; i < BL; i++)
      if (i >= w_q.size() || w_q[i] !== first + DW'(i)) errs++;
    total++;
    if (w_q.size() != BL || errs != 0) begin
      bad++;
      $display("FAIL %s_wdata: got %0d beats with %0d wrong, want %0d beats from %h", name, w_q.size(), errs, BL, first);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, init_axi_txn_done, busy, txn_error, overflow, m_axi_wlast} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, init_axi_txn_done, busy, txn_error, overflow, m_axi_wlast});
    end
    total++;
    if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_buses: awaddr=%h wdata=%h want 0", m_axi_awaddr, m_axi_wdata);
    end
    total++;
    if (m_axi_awlen !== 8'd15 || m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01 || m_axi_wstrb !== 4'hF) begin
      bad++;
      $display("FAIL reset_consts: awlen=%0d awsize=%0d awburst=%b wstrb=%h want 15 2 01 f", m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_burst();
    clear_mon();
    trigger(32'h1000_0000, 32'h0000_0040);
    total++;
    if (m_axi_awvalid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_aw_latency: awvalid=%b busy=%b want 1 1", m_axi_awvalid, busy);
    end
    send_beats(BL, 32'h0);
    wait_done("basic");
    total++;
    if (aw_count != 1 || aw_addr_seen !== 32'h1000_0040) begin
      bad++;
      $display("FAIL basic_aw: count=%0d addr=%h want 1 10000040", aw_count, aw_addr_seen);
    end
    check_data("basic", 32'h0);
    total++;
    if (wlast_count != 1 || wlast_idx != BL - 1) begin
      bad++;
      $display("FAIL basic_wlast: count=%0d idx=%0d want 1 15", wlast_count, wlast_idx);
    end
    total++;
    if (done_count != 1 || done_cyc != resp_cyc + 1) begin
      bad++;
      $display("FAIL basic_done: pulses=%0d at %0d want 1 at %0d", done_count, done_cyc, resp_cyc + 1);
    end
    total++;
    if (txn_error !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_status: err=%b ovf=%b busy=%b want 0 0 0", txn_error, overflow, busy);
    end
  endtask

  task automatic test_backpressure();
    aw_delay_en = 1'b1;
    wtoggle = 1'b1;
    tick();
    clear_mon();
    trigger(32'h2000_0000, 32'h0000_0100);
    send_beats(BL, 32'hA0);
    wait_done("bp");
    check_data("bp", 32'hA0);
    total++;
    if (aw_count != 1 || aw_hs_cyc - wlast_cyc < 10) begin
      bad++;
      $display("FAIL bp_aw_order: aw_count=%0d aw_cyc=%0d wlast_cyc=%0d want 1 and gap>=10", aw_count, aw_hs_cyc, wlast_cyc);
    end
    total++;
    if (resp_cyc <= aw_hs_cyc || done_count != 1) begin
      bad++;
      $display("FAIL bp_resp: resp_cyc=%0d aw_cyc=%0d done=%0d want resp after aw and done 1", resp_cyc, aw_hs_cyc, done_count);
    end
    aw_delay_en = 1'b0;
    wtoggle = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    clear_mon();
    trigger(32'h3000_0000, 32'h0);
    send_beats(BL + 2, 32'h100);
    wait_done("ovf");
    check_data("ovf", 32'h100);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
  endtask

  task automatic test_error_resp();
    resp_code = 2'b10;
    clear_mon();
    trigger(32'h4000_0000, 32'h0);
    send_beats(BL, 32'h200);
    wait_done("err");
    total++;
    if (err_at_done !== 1'b1 || txn_error !== 1'b1) begin
      bad++;
      $display("FAIL err_flag: at_done=%b after=%b want 1 1", err_at_done, txn_error);
    end
    resp_code = 2'b00;
    clear_mon();
    trigger(32'h4000_0000, 32'h400);
    total++;
    if (txn_error !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b ovf=%b want 0 0", txn_error, overflow);
    end
    send_beats(BL, 32'h300);
    wait_done("err_ok");
    total++;
    if (txn_error !== 1'b0 || done_count != 1) begin
      bad++;
      $display("FAIL err_ok: err=%b done=%0d want 0 1", txn_error, done_count);
    end
  endtask

  task automatic test_retrigger_and_abort();
    clear_mon();
    trigger(32'h5000_0000, 32'h0);
    send_beats(4, 32'h400);
    init_axi_txn = 1'b1;
    send_beats(1, 32'h404);
    init_axi_txn = 1'b0;
    send_beats(BL - 5, 32'h405);
    wait_done("retrig");
    total++;
    if (aw_count != 1 || done_count != 1 || w_q.size() != BL) begin
      bad++;
      $display("FAIL retrig: aw=%0d done=%0d beats=%0d want 1 1 16", aw_count, done_count, w_q.size());
    end

    aw_delay_en = 1'b1;
    tick();
    clear_mon();
    trigger(32'h5000_1000, 32'h0);
    send_beats(7, 32'h500);
    total++;
    if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: awvalid=%b wvalid=%b want 1 1", m_axi_awvalid, m_axi_wvalid);
    end
    data_en = 1'b1;
    data = 32'h507;
    rst = 1'b1;
    tick();
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, init_axi_txn_done} !== 5'b0) begin
      bad++;
      $display("FAIL abort_valids: aw,w,b,busy,done=%b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, init_axi_txn_done});
    end
    rst = 1'b0;
    data_en = 1'b0;
    aw_delay_en = 1'b0;
    repeat (20) tick();
    total++;
    if (done_count != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone: done=%0d busy=%b want 0 0", done_count, busy);
    end
  endtask

  task automatic test_addr_wrap();
    clear_mon();
    trigger(32'hFFFF_FFC0, 32'h0000_0080);
    send_beats(BL, 32'h600);
    wait_done("wrap");
    total++;
    if (aw_addr_seen !== 32'h0000_0040 || aw_count != 1) begin
      bad++;
      $display("FAIL wrap_addr: got %h count=%0d want 00000040 1", aw_addr_seen, aw_count);
    end
    check_data("wrap", 32'h600);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_overflow();
    test_error_resp();
    test_retrigger_and_abort();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
